// File: rtl/game_if.sv
// game_if: mouse/vsync inputs and game-state outputs shared by game_ctrl and its peers.
interface game_if;
  logic vsync;
  logic mouse_left;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic [2:0] screen_sel;
  logic [1:0] keeper_zone;
  logic [3:0] round_no;
  logic [3:0] goals;
  logic result_valid;
  modport master (
    output vsync, mouse_left, xpos, ypos,
    input  screen_sel, keeper_zone, round_no, goals, result_valid
  );
  modport slave (
    input  vsync, mouse_left, xpos, ypos,
    output screen_sel, keeper_zone, round_no, goals, result_valid
  );
endinterface

// File: rtl/game_ctrl.sv
// game_ctrl: penalty-game sequencer (rounds, score, shot timing, keeper zone, screen select).
// Define FRAME_SYNC_SEL_EN to update screen_sel only at frame start.
module game_ctrl #(
  parameter int ROUNDS        = 5,
  parameter int SHOT_FRAMES   = 180,
  parameter int RESULT_FRAMES = 90,
  parameter int GOAL_X0       = 256,
  parameter int ZONE_W        = 170,
  parameter int GOAL_Y0       = 200,
  parameter int GOAL_Y1       = 440
) (
  input logic clk,
  input logic rst,
  game_if.slave g
);
  typedef enum logic [2:0] {IDLE, SHOOT, GOAL, SAVED, MISS, END} state_t;
  localparam logic [12:0] XA = 13'(GOAL_X0);
  localparam logic [12:0] XB = 13'(GOAL_X0 + ZONE_W);
  localparam logic [12:0] XC = 13'(GOAL_X0 + 2 * ZONE_W);
  localparam logic [12:0] XD = 13'(GOAL_X0 + 3 * ZONE_W);
  localparam logic [12:0] YA = 13'(GOAL_Y0);
  localparam logic [12:0] YB = 13'(GOAL_Y1);
  state_t state, state_n, outcome;
  logic [7:0] fcnt, fcnt_n, lfsr;
  logic [3:0] round_n, goals_n;
  logic [1:0] zone_n, shot_zone, samp;
  logic [12:0] x, y;
  logic [2:0] code;
  logic rv_n, left_q, vs_q, click, tick, in_goal;
`ifdef FRAME_SYNC_SEL_EN
  logic tick_q;
`endif
  assign click = g.mouse_left & ~left_q;
  assign tick = g.vsync & ~vs_q;
  assign x = {1'b0, g.xpos};
  assign y = {1'b0, g.ypos};
  assign in_goal = x >= XA && x < XD && y >= YA && y < YB;
  assign shot_zone = x < XB ? 2'd0 : x < XC ? 2'd1 : 2'd2;
  assign samp = &lfsr[1:0] ? 2'd1 : lfsr[1:0];
  assign outcome = !in_goal ? MISS : shot_zone == g.keeper_zone ? SAVED : GOAL;
  // START..MISS map straight onto their enum encoding; END splits into WIN/LOSE
  assign code = state == END ? (({g.goals, 1'b0} > 5'(ROUNDS)) ? 3'd5 : 3'd6) : 3'(state);
  always_comb begin
    state_n = state;
    fcnt_n = fcnt;
    round_n = g.round_no;
    goals_n = g.goals;
    zone_n = g.keeper_zone;
    rv_n = 1'b0;
    case (state)
      IDLE: if (click) begin
        state_n = SHOOT;
        zone_n = samp;
        fcnt_n = '0;
      end
      SHOOT: if (click || (tick && fcnt == 8'(SHOT_FRAMES - 1))) begin
        state_n = click ? outcome : MISS;
        goals_n = (click && outcome == GOAL && g.goals < 4'(ROUNDS)) ? g.goals + 4'd1 : g.goals;
        round_n = g.round_no < 4'(ROUNDS) ? g.round_no + 4'd1 : g.round_no;
        rv_n = 1'b1;
        fcnt_n = '0;
      end else if (tick) fcnt_n = fcnt + 8'd1;
      GOAL, SAVED, MISS: if (tick) begin
        if (fcnt == 8'(RESULT_FRAMES - 1)) begin
          fcnt_n = '0;
          state_n = g.round_no == 4'(ROUNDS) ? END : SHOOT;
          zone_n = g.round_no == 4'(ROUNDS) ? g.keeper_zone : samp;
        end else fcnt_n = fcnt + 8'd1;
      end
      END: if (click) begin
        state_n = IDLE;
        round_n = '0;
        goals_n = '0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      fcnt <= '0;
      lfsr <= 8'hA5;
      left_q <= 1'b0;
      vs_q <= 1'b0;
      g.screen_sel <= '0;
      g.keeper_zone <= 2'd1;
      g.round_no <= '0;
      g.goals <= '0;
      g.result_valid <= 1'b0;
`ifdef FRAME_SYNC_SEL_EN
      tick_q <= 1'b0;
`endif
    end else begin
      state <= state_n;
      fcnt <= fcnt_n;
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      left_q <= g.mouse_left;
      vs_q <= g.vsync;
      g.keeper_zone <= zone_n;
      g.round_no <= round_n;
      g.goals <= goals_n;
      g.result_valid <= rv_n;
`ifdef FRAME_SYNC_SEL_EN
      tick_q <= tick;
      if (tick_q) g.screen_sel <= code;
`else
      g.screen_sel <= code;
`endif
    end
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed checks of game_ctrl with hand-computed expectations.
module tb_game_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] m_lfsr;
  logic [1:0] pz, kz_e;
  int total = 0;
  int bad = 0;
  game_if g();
  game_ctrl dut (.clk(clk), .rst(rst), .g(g));
  always #5 clk = ~clk;
  // reference keeper-zone source: 8-bit Fibonacci LFSR, taps 8,6,5,4, seed A5
  always @(posedge clk or negedge rst)
    if (!rst) m_lfsr <= 8'hA5;
    else m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  function automatic logic [1:0] zmap(logic [7:0] l);
    return l[1:0] == 2'd3 ? 2'd1 : l[1:0];
  endfunction
  function automatic int zx(int z);
    return 256 + 170 * z + 85;
  endfunction
  task automatic chk(string tag, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic click(int x, int y);
    g.mouse_left = 1'b1;
    g.xpos = 12'(x);
    g.ypos = 12'(y);
    pz = zmap(m_lfsr);
    @(negedge clk);
    g.mouse_left = 1'b0;
  endtask
  task automatic tick();
    g.vsync = 1'b1;
    pz = zmap(m_lfsr);
    @(negedge clk);
    g.vsync = 1'b0;
    @(negedge clk);
  endtask
  task automatic shot(string tag, int x, int y, int scr, int gl, int rn);
    click(x, y);
    chk({tag, "_rv"}, g.result_valid, 1);
    chk({tag, "_goals"}, g.goals, gl);
    chk({tag, "_round"}, g.round_no, rn);
    step();
    chk({tag, "_scr"}, g.screen_sel, scr);
    chk({tag, "_rv_off"}, g.result_valid, 0);
  endtask
  task automatic hold(int cur, int nxt, int n);
    repeat (n - 1) tick();
    chk("hold_scr", g.screen_sel, cur);
    tick();
    chk("hold_next", g.screen_sel, nxt);
    if (nxt == 1) begin
      kz_e = pz;
      chk("resample_kz", g.keeper_zone, kz_e);
    end
  endtask
  task automatic start_game();
    click(0, 0);
    kz_e = pz;
    chk("start_kz", g.keeper_zone, kz_e);
    chk("start_kz_range", int'(g.keeper_zone < 2'd3), 1);
    step();
    chk("start_scr", g.screen_sel, 1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    g.vsync = 1'b0;
    g.mouse_left = 1'b0;
    g.xpos = '0;
    g.ypos = '0;
    #2 rst = 1'b0;
    repeat (3) step();
    chk("rst_scr", g.screen_sel, 0);
    chk("rst_kz", g.keeper_zone, 1);
    chk("rst_round", g.round_no, 0);
    chk("rst_goals", g.goals, 0);
    chk("rst_rv", g.result_valid, 0);
    rst = 1'b1;
    step();
    // game 1: goal, save, off-target miss, timeout, click on the final tick -> 2 goals, LOSE
    start_game();
    shot("g1s1", zx((kz_e + 1) % 3), 300, 2, 1, 1);
    repeat (45) tick();
    click(zx(kz_e), 300);
    chk("ign_rv", g.result_valid, 0);
    chk("ign_goals", g.goals, 1);
    step();
    chk("ign_scr", g.screen_sel, 2);
    hold(2, 1, 45);
    shot("g1s2", zx(kz_e), 300, 3, 1, 2);
    hold(3, 1, 90);
    shot("g1s3", 100, 300, 4, 1, 3);
    hold(4, 1, 90);
    repeat (179) tick();
    chk("to_wait_scr", g.screen_sel, 1);
    chk("to_wait_round", g.round_no, 3);
    g.vsync = 1'b1;
    @(negedge clk);
    g.vsync = 1'b0;
    chk("to_rv", g.result_valid, 1);
    chk("to_round", g.round_no, 4);
    step();
    chk("to_scr", g.screen_sel, 4);
    hold(4, 1, 90);
    repeat (179) tick();
    g.vsync = 1'b1;
    g.mouse_left = 1'b1;
    g.xpos = 12'(zx((kz_e + 1) % 3));
    g.ypos = 12'd300;
    @(negedge clk);
    g.vsync = 1'b0;
    g.mouse_left = 1'b0;
    chk("co_rv", g.result_valid, 1);
    chk("co_goals", g.goals, 2);
    chk("co_round", g.round_no, 5);
    step();
    chk("co_scr", g.screen_sel, 2);
    hold(2, 6, 90);
    click(0, 0);
    chk("end_round", g.round_no, 0);
    chk("end_goals", g.goals, 0);
    step();
    chk("end_scr", g.screen_sel, 0);
    // game 2: three goals at edge y values, then misses on the exclusive x and y edges -> WIN
    start_game();
    shot("g2s1", zx((kz_e + 1) % 3), 200, 2, 1, 1);
    hold(2, 1, 90);
    shot("g2s2", zx((kz_e + 1) % 3), 439, 2, 2, 2);
    hold(2, 1, 90);
    shot("g2s3", zx((kz_e + 1) % 3), 300, 2, 3, 3);
    hold(2, 1, 90);
    shot("g2s4", 766, 300, 4, 3, 4);
    hold(4, 1, 90);
    shot("g2s5", 511, 440, 4, 3, 5);
    hold(4, 5, 90);
    click(0, 0);
    step();
    chk("end2_scr", g.screen_sel, 0);
    // game 3: reach SHOOT with 2 goals, then asynchronous reset
    start_game();
    shot("g3s1", zx((kz_e + 1) % 3), 300, 2, 1, 1);
    hold(2, 1, 90);
    shot("g3s2", zx((kz_e + 2) % 3), 300, 2, 2, 2);
    hold(2, 1, 90);
    chk("pre_rst_goals", g.goals, 2);
    #2 rst = 1'b0;
    #1;
    chk("arst_scr", g.screen_sel, 0);
    chk("arst_kz", g.keeper_zone, 1);
    chk("arst_round", g.round_no, 0);
    chk("arst_goals", g.goals, 0);
    chk("arst_rv", g.result_valid, 0);
    step();
    rst = 1'b1;
    step();
    step();
    chk("post_rst_scr", g.screen_sel, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
